mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AWIDTH, default 5, memory address width.
REQ-002 SHALL have parameter DWIDTH, default 8, memory data width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports req_0 / req_1  input  1  access request from port 0 (CPU) / port 1 (loader).
REQ-006 SHALL have ports wr_0 / wr_1  input  1  1 = write, 0 = read, sampled with req.
REQ-007 SHALL have ports addr_0 / addr_1  input  AWIDTH  access address.
REQ-008 SHALL have ports wdata_0 / wdata_1  input  DWIDTH  write data.
REQ-009 SHALL have ports ack_0 / ack_1  output  1  one-cycle completion pulse.
REQ-010 SHALL have ports rdata_0 / rdata_1  output  DWIDTH  read result, valid while matching ack high.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have ports mem_rd / mem_wr  output  1  memory read / write strobes.
REQ-013 SHALL have port mem_addr  output  AWIDTH  memory address.
REQ-014 SHALL have port mem_wdata  output  DWIDTH  data to the bus driver.
REQ-015 SHALL have port mem_data_e  output  1  bus driver enable, high only during a write strobe.
REQ-016 SHALL have port mem_rdata  input  DWIDTH  data read back from memory.

Function
REQ-017 SHALL implement FSM with states IDLE, ACCESS and ACK; IDLE->ACCESS when any req is high, ACCESS->ACK unconditionally, ACK->IDLE unconditionally.
REQ-018 SHALL sample req_0/req_1 in IDLE only; requests raised in ACCESS or ACK wait until the next IDLE.
REQ-019 SHALL, on the IDLE->ACCESS edge, latch the winner id and its wr, addr and wdata into internal registers; later changes on requester inputs have no effect.
REQ-020 SHALL, in ACCESS, drive mem_addr and mem_wdata from the latched values, assert mem_rd for a read or mem_wr plus mem_data_e for a write, and hold all strobes low in every other state.
REQ-021 SHALL capture mem_rdata at the end of ACCESS for a read and present it on the winner's rdata; rdata holds its value until the next read completes for that port.
REQ-022 SHALL pulse the winner's ack for exactly the ACK cycle; the other ack stays low.
REQ-023 SHALL give a latency of 2 cycles from the edge sampling req high in IDLE to ack high, and a throughput of one access per 3 cycles.
REQ-024 SHALL treat a req still high in the cycle after ACK (IDLE) as a new request; requesters drop req on seeing ack.
REQ-025 SHALL, on simultaneous req_0 and req_1, grant per the REQ-029/REQ-030 policy; the loser keeps waiting with no ack.
REQ-026 SHALL ignore wr/addr/wdata of a port whose req is low.

Reset
REQ-027 SHALL, while rst is high at a clock edge, force state IDLE, ack_0 = ack_1 = 0, rdata_0 = rdata_1 = 0, all mem strobes and mem_data_e = 0, mem_addr = 0, mem_wdata = 0, busy = 0, and the round-robin pointer = port 0.
REQ-028 SHALL abort any in-flight access on reset with no ack issued; a write aborted before ACCESS leaves memory untouched.

Configuration
REQ-029 SHALL, with macro MEM_ARBITER_ROUND_ROBIN_EN defined, grant contention to the port indicated by the pointer and set the pointer to the other port after each grant.
REQ-030 SHALL, without MEM_ARBITER_ROUND_ROBIN_EN, use fixed priority with port 0 always winning contention and no pointer register.

Verification
REQ-031 SHALL cover a single read: mem[5] = 0x3C, req_0 = 1, wr_0 = 0, addr_0 = 5 -> mem_rd high for 1 cycle with mem_addr = 5, then ack_0 = 1 with rdata_0 = 0x3C two cycles after the request is sampled.
REQ-032 SHALL cover a single write: req_1 = 1, wr_1 = 1, addr_1 = 0x1F, wdata_1 = 0xA5 -> exactly one cycle of mem_wr = mem_data_e = 1 with mem_addr = 0x1F and mem_wdata = 0xA5, then ack_1 = 1; a later read of 0x1F returns 0xA5.
REQ-033 SHALL cover contention: both req held high for 4 transactions -> with ROUND_ROBIN_EN, ack order 0,1,0,1; without it, ack order 0,0,0,0 and port 1 is never acked.
REQ-034 SHALL cover reset mid-operation: rst = 1 during ACCESS of a write to addr 3 -> no ack, busy = 0 next cycle, and all strobes/outputs at the REQ-027 values.
REQ-035 SHALL cover input stability: change addr_0 from 2 to 9 during ACCESS -> mem_addr stays 2 for the whole access.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle for the two-port memory arbiter: requester handshakes plus the memory-side strobes.
// The slave modport is the arbiter's view; the master modport is the requesters/memory environment.
interface mem_arbiter_if #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
);
    logic              req_0;
    logic              req_1;
    logic              wr_0;
    logic              wr_1;
    logic [AWIDTH-1:0] addr_0;
    logic [AWIDTH-1:0] addr_1;
    logic [DWIDTH-1:0] wdata_0;
    logic [DWIDTH-1:0] wdata_1;
    logic              ack_0;
    logic              ack_1;
    logic [DWIDTH-1:0] rdata_0;
    logic [DWIDTH-1:0] rdata_1;
    logic              busy;
    logic              mem_rd;
    logic              mem_wr;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_wdata;
    logic              mem_data_e;
    logic [DWIDTH-1:0] mem_rdata;

    modport slave (
        input  req_0, req_1, wr_0, wr_1, addr_0, addr_1, wdata_0, wdata_1, mem_rdata,
        output ack_0, ack_1, rdata_0, rdata_1, busy,
        output mem_rd, mem_wr, mem_addr, mem_wdata, mem_data_e
    );

    modport master (
        output req_0, req_1, wr_0, wr_1, addr_0, addr_1, wdata_0, wdata_1, mem_rdata,
        input  ack_0, ack_1, rdata_0, rdata_1, busy,
        input  mem_rd, mem_wr, mem_addr, mem_wdata, mem_data_e
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: IDLE -> ACCESS -> ACK, one access per three cycles.
// Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin contention; default is fixed priority to port 0.
module mem_arbiter #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, ACK = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [1:0]        req_w;
    logic              start_w;
    logic              grant_id;
    logic              id_q;
    logic              wr_q;
    logic [AWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] wdata_q;
    logic [DWIDTH-1:0] rdata_q [2];

    assign req_w   = {bus.req_1, bus.req_0};
    assign start_w = (state_q == IDLE) && (|req_w);

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    logic ptr_q;

    // Contention goes to the pointed-at port; a lone request always wins.
    assign grant_id = (&req_w) ? ptr_q : req_w[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else if (start_w) begin
            ptr_q <= ~grant_id;
        end
    end
`else
    assign grant_id = ~req_w[0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req_w) state_d = ACCESS;
            ACCESS:  state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Winner's request is frozen here so requester inputs are don't-care until the next IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (start_w) begin
            id_q    <= grant_id;
            wr_q    <= grant_id ? bus.wr_1    : bus.wr_0;
            addr_q  <= grant_id ? bus.addr_1  : bus.addr_0;
            wdata_q <= grant_id ? bus.wdata_1 : bus.wdata_0;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        localparam logic PORT_ID = 1'(gi);

        always_ff @(posedge clk) begin
            if (rst) begin
                rdata_q[gi] <= '0;
            end else if (state_q == ACCESS && !wr_q && id_q == PORT_ID) begin
                rdata_q[gi] <= bus.mem_rdata;
            end
        end
    end

    assign bus.rdata_0 = rdata_q[0];
    assign bus.rdata_1 = rdata_q[1];

    always_comb begin
        bus.busy       = (state_q != IDLE);
        bus.mem_rd     = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.mem_data_e = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.ack_0      = (state_q == ACK) && !id_q;
        bus.ack_1      = (state_q == ACK) &&  id_q;
        if (state_q == ACCESS) begin
            bus.mem_addr   = addr_q;
            bus.mem_wdata  = wdata_q;
            bus.mem_rd     = !wr_q;
            bus.mem_wr     = wr_q;
            bus.mem_data_e = wr_q;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 32x8 memory on the bus side.
module tb_mem_arbiter;
    logic clk;
    logic rst;
    int   passed;
    int   total;
    logic [7:0] mem [32];

    mem_arbiter_if #(.AWIDTH(5), .DWIDTH(8)) bus ();

    mem_arbiter #(.AWIDTH(5), .DWIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
    assign bus.mem_rdata = mem[bus.mem_addr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit port, input bit wr, input logic [4:0] addr, input logic [7:0] data);
        if (port) begin
            bus.req_1 = 1'b1; bus.wr_1 = wr; bus.addr_1 = addr; bus.wdata_1 = data;
        end else begin
            bus.req_0 = 1'b1; bus.wr_0 = wr; bus.addr_0 = addr; bus.wdata_0 = data;
        end
        $display("txn port%0d %s addr=%h data=%h", port, wr ? "write" : "read", addr, data);
    endtask

    // Unchecked setup access: request, wait for the ACK cycle, drop, return to IDLE.
    task automatic run_access(input bit port, input bit wr, input logic [4:0] addr, input logic [7:0] data);
        drive(port, wr, addr, data);
        step();
        step();
        bus.req_0 = 1'b0;
        bus.req_1 = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else passed++;
        total++; if ({bus.ack_0, bus.ack_1} !== 2'b00) $display("FAIL reset_ack: got %b expected 00", {bus.ack_0, bus.ack_1}); else passed++;
        total++; if ({bus.rdata_0, bus.rdata_1} !== 16'h0) $display("FAIL reset_rdata: got %h expected 0000", {bus.rdata_0, bus.rdata_1}); else passed++;
        total++; if ({bus.mem_rd, bus.mem_wr, bus.mem_data_e} !== 3'b000) $display("FAIL reset_strobes: got %b expected 000", {bus.mem_rd, bus.mem_wr, bus.mem_data_e}); else passed++;
        total++; if ({bus.mem_addr, bus.mem_wdata} !== 13'h0) $display("FAIL reset_bus: got %h expected 0", {bus.mem_addr, bus.mem_wdata}); else passed++;
        rst = 1'b0;
        $display("txn reset released");
    endtask

    task automatic test_single_write();
        drive(1'b1, 1'b1, 5'h1F, 8'hA5);
        step();
        total++; if ({bus.mem_wr, bus.mem_data_e, bus.mem_rd} !== 3'b110) $display("FAIL write_strobes: got %b expected 110", {bus.mem_wr, bus.mem_data_e, bus.mem_rd}); else passed++;
        total++; if (bus.mem_addr !== 5'h1F) $display("FAIL write_addr: got %h expected 1f", bus.mem_addr); else passed++;
        total++; if (bus.mem_wdata !== 8'hA5) $display("FAIL write_wdata: got %h expected a5", bus.mem_wdata); else passed++;
        total++; if (bus.busy !== 1'b1 || bus.ack_1 !== 1'b0) $display("FAIL write_access_state: got busy=%b ack_1=%b expected 1/0", bus.busy, bus.ack_1); else passed++;
        step();
        total++; if ({bus.ack_1, bus.ack_0} !== 2'b10) $display("FAIL write_ack: got %b expected 10", {bus.ack_1, bus.ack_0}); else passed++;
        total++; if ({bus.mem_wr, bus.mem_data_e} !== 2'b00) $display("FAIL write_single_strobe: got %b expected 00", {bus.mem_wr, bus.mem_data_e}); else passed++;
        bus.req_1 = 1'b0;
        step();
        total++; if ({bus.ack_1, bus.busy} !== 2'b00) $display("FAIL write_idle: got %b expected 00", {bus.ack_1, bus.busy}); else passed++;
    endtask

    task automatic test_single_read();
        run_access(1'b0, 1'b1, 5'd5, 8'h3C);
        drive(1'b0, 1'b0, 5'd5, 8'h00);
        step();
        total++; if ({bus.mem_rd, bus.mem_wr, bus.mem_data_e} !== 3'b100) $display("FAIL read_strobes: got %b expected 100", {bus.mem_rd, bus.mem_wr, bus.mem_data_e}); else passed++;
        total++; if (bus.mem_addr !== 5'd5) $display("FAIL read_addr: got %h expected 05", bus.mem_addr); else passed++;
        step();
        total++; if ({bus.ack_0, bus.ack_1} !== 2'b10) $display("FAIL read_ack: got %b expected 10", {bus.ack_0, bus.ack_1}); else passed++;
        total++; if (bus.rdata_0 !== 8'h3C) $display("FAIL read_rdata: got %h expected 3c", bus.rdata_0); else passed++;
        total++; if (bus.mem_rd !== 1'b0) $display("FAIL read_single_strobe: got %b expected 0", bus.mem_rd); else passed++;
        bus.req_0 = 1'b0;
        step();
        total++; if (bus.rdata_0 !== 8'h3C || bus.ack_0 !== 1'b0) $display("FAIL read_hold: got rdata=%h ack=%b expected 3c/0", bus.rdata_0, bus.ack_0); else passed++;
    endtask

    task automatic test_stability();
        run_access(1'b1, 1'b1, 5'd2, 8'h22);
        drive(1'b0, 1'b0, 5'd2, 8'h00);
        step();
        total++; if (bus.mem_addr !== 5'd2) $display("FAIL stab_addr_start: got %h expected 02", bus.mem_addr); else passed++;
        bus.addr_0 = 5'd9;
        drive(1'b1, 1'b0, 5'h1F, 8'h00);
        #3;
        total++; if (bus.mem_addr !== 5'd2) $display("FAIL stab_addr_late: got %h expected 02", bus.mem_addr); else passed++;
        step();
        total++; if ({bus.ack_0, bus.ack_1} !== 2'b10) $display("FAIL stab_ack: got %b expected 10", {bus.ack_0, bus.ack_1}); else passed++;
        total++; if (bus.rdata_0 !== 8'h22) $display("FAIL stab_rdata: got %h expected 22", bus.rdata_0); else passed++;
        bus.req_0 = 1'b0;
        step();
        total++; if (bus.busy !== 1'b0) $display("FAIL late_req_waits: got busy=%b expected 0", bus.busy); else passed++;
        step();
        step();
        total++; if ({bus.ack_1, bus.ack_0} !== 2'b10) $display("FAIL late_req_ack: got %b expected 10", {bus.ack_1, bus.ack_0}); else passed++;
        total++; if (bus.rdata_1 !== 8'hA5) $display("FAIL readback_1f: got %h expected a5", bus.rdata_1); else passed++;
        total++; if (bus.rdata_0 !== 8'h22) $display("FAIL rdata0_untouched: got %h expected 22", bus.rdata_0); else passed++;
        bus.req_1 = 1'b0;
        step();
    endtask

    task automatic test_contention();
        bit exp_order [4];
        bit got_order [4];
        int ack_cyc   [4];
        int n_acks;
        int both_hi;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_order = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        n_acks = 0;
        both_hi = 0;
        drive(1'b0, 1'b0, 5'd5, 8'h00);
        drive(1'b1, 1'b0, 5'h1F, 8'h00);
        for (int c = 1; c <= 20 && n_acks < 4; c++) begin
            step();
            if (bus.ack_0 && bus.ack_1) both_hi++;
            if (bus.ack_0 || bus.ack_1) begin
                got_order[n_acks] = bus.ack_1;
                ack_cyc[n_acks]   = c;
                n_acks++;
                $display("txn contention ack port%0d at cycle %0d", bus.ack_1, c);
            end
        end
        bus.req_0 = 1'b0;
        bus.req_1 = 1'b0;
        total++; if (n_acks != 4) $display("FAIL contention_count: got %0d acks expected 4", n_acks); else passed++;
        total++; if (both_hi != 0) $display("FAIL contention_dual_ack: got %0d expected 0", both_hi); else passed++;
        for (int i = 0; i < n_acks; i++) begin
            total++; if (got_order[i] !== exp_order[i]) $display("FAIL contention_order%0d: got port%0d expected port%0d", i, got_order[i], exp_order[i]); else passed++;
        end
        total++; if (n_acks > 0 && ack_cyc[0] != 2) $display("FAIL contention_latency: got %0d expected 2", ack_cyc[0]); else passed++;
        for (int i = 1; i < n_acks; i++) begin
            total++; if (ack_cyc[i] - ack_cyc[i-1] != 3) $display("FAIL contention_spacing%0d: got %0d expected 3", i, ack_cyc[i] - ack_cyc[i-1]); else passed++;
        end
        step();
        step();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 5'd3, 8'h77);
        step();
        total++; if (bus.mem_wr !== 1'b1 || bus.mem_addr !== 5'd3) $display("FAIL rstmid_access: got wr=%b addr=%h expected 1/03", bus.mem_wr, bus.mem_addr); else passed++;
        rst = 1'b1;
        step();
        total++; if ({bus.ack_0, bus.ack_1, bus.busy} !== 3'b000) $display("FAIL rstmid_ack_busy: got %b expected 000", {bus.ack_0, bus.ack_1, bus.busy}); else passed++;
        total++; if ({bus.mem_rd, bus.mem_wr, bus.mem_data_e} !== 3'b000) $display("FAIL rstmid_strobes: got %b expected 000", {bus.mem_rd, bus.mem_wr, bus.mem_data_e}); else passed++;
        total++; if ({bus.mem_addr, bus.mem_wdata, bus.rdata_0, bus.rdata_1} !== 29'h0) $display("FAIL rstmid_outputs: got %h expected 0", {bus.mem_addr, bus.mem_wdata, bus.rdata_0, bus.rdata_1}); else passed++;
        bus.req_1 = 1'b0;
        rst = 1'b0;
        step();
        total++; if ({bus.ack_1, bus.busy} !== 2'b00) $display("FAIL rstmid_no_late_ack: got %b expected 00", {bus.ack_1, bus.busy}); else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst = 1'b1;
        bus.req_0 = 1'b0; bus.wr_0 = 1'b0; bus.addr_0 = '0; bus.wdata_0 = '0;
        bus.req_1 = 1'b0; bus.wr_1 = 1'b0; bus.addr_1 = '0; bus.wdata_1 = '0;
        test_reset();
        test_single_write();
        test_single_read();
        test_stability();
        test_reset();
        test_contention();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
